muldiv_unit: RTL and testbench

- Iterative multiply/divide unit directly downstream of the 16-bit, 8-entry register file.
- Consumes the two read-port operands (ReadData1 -> src_a, ReadData2 -> src_b) under a start/busy/done handshake.
- Computes one result bit per cycle and holds the 32-bit result in HI/LO registers until the next completion.
- The multicycle controller stalls on busy and later moves hi/lo back through the register-file write port (MFHI/MFLO).

---
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative 1-bit-per-cycle multiply/divide with HI/LO result regs
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module muldiv_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int            CW         = $clog2(WIDTH);
   localparam logic [CW-1:0] c_lastStep = CW'(WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t r_state, w_stateNext;

   logic                 r_isDiv;
   logic                 r_negRes;
   logic                 r_negDividend;
   logic [WIDTH-1:0]     r_magA;
   logic [WIDTH-1:0]     r_magB;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_acc;
   logic                 r_done;
   logic                 r_dbz;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;

   logic                 w_accept;
   logic                 w_last;
   logic                 w_signA;
   logic                 w_signB;
   logic [WIDTH-1:0]     w_absA;
   logic [WIDTH-1:0]     w_absB;
   logic [WIDTH-1:0]     w_addend;
   logic [WIDTH:0]       w_mulAdd;
   logic [2*WIDTH-1:0]   w_mulNext;
   logic [WIDTH:0]       w_remShift;
   logic                 w_divGe;
   logic [WIDTH-1:0]     w_divDiff;
   logic [2*WIDTH-1:0]   w_divNext;
   logic [2*WIDTH-1:0]   w_accNext;
   logic [WIDTH-1:0]     w_quo;
   logic [WIDTH-1:0]     w_rem;
   logic                 w_dbz;
   logic [WIDTH-1:0]     w_resHi;
   logic [WIDTH-1:0]     w_resLo;

   assign w_accept = (r_state == IDLE) && start;
   assign w_last   = (r_state == CALC) && (r_cnt == c_lastStep);

   // op[0] selects the signed variants; unsigned operands never get a sign flag
   assign w_signA = op[0] & src_a[WIDTH-1];
   assign w_signB = op[0] & src_b[WIDTH-1];
   assign w_absA  = w_signA ? -src_a : src_a;
   assign w_absB  = w_signB ? -src_b : src_b;

   // Multiply: acc = {partial product, remaining multiplier bits}, shift right
   assign w_addend  = r_acc[0] ? r_magA : '0;
   assign w_mulAdd  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
   assign w_mulNext = {w_mulAdd, r_acc[WIDTH-1:1]};

   // Restoring divide: acc = {remainder, dividend/quotient bits}, shift left
   assign w_remShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_divGe    = w_remShift >= {1'b0, r_magB};
   assign w_divDiff  = w_remShift[WIDTH-1:0] - r_magB;
   assign w_divNext  = {(w_divGe ? w_divDiff : w_remShift[WIDTH-1:0]),
                        r_acc[WIDTH-2:0], w_divGe};

   assign w_accNext = r_isDiv ? w_divNext : w_mulNext;
   assign w_quo     = w_divNext[WIDTH-1:0];
   assign w_rem     = w_divNext[2*WIDTH-1:WIDTH];
   assign w_dbz     = r_isDiv && (r_magB == '0);

   always_comb begin
      w_resHi = '0;
      w_resLo = '0;
      if (!r_isDiv) begin
         {w_resHi, w_resLo} = r_negRes ? -w_mulNext : w_mulNext;
      end else if (w_dbz) begin
         w_resLo = '1;
         w_resHi = r_negDividend ? -r_magA : r_magA;
      end else begin
         w_resLo = r_negRes      ? -w_quo : w_quo;
         w_resHi = r_negDividend ? -w_rem : w_rem;
      end
   end

   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         IDLE:    if (start) w_stateNext = CALC;
         CALC:    if (r_cnt == c_lastStep) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_stateNext;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_isDiv       <= 1'b0;
         r_negRes      <= 1'b0;
         r_negDividend <= 1'b0;
         r_magA        <= '0;
         r_magB        <= '0;
         r_cnt         <= '0;
         r_acc         <= '0;
         r_done        <= 1'b0;
         r_dbz         <= 1'b0;
         r_hi          <= '0;
         r_lo          <= '0;
      end else begin
         r_done <= w_last;
         if (w_accept) begin
            r_isDiv       <= op[1];
            r_negRes      <= w_signA ^ w_signB;
            r_negDividend <= w_signA;
            r_magA        <= w_absA;
            r_magB        <= w_absB;
            r_cnt         <= '0;
            r_acc         <= {{WIDTH{1'b0}}, (op[1] ? w_absA : w_absB)};
         end else if (r_state == CALC) begin
            r_acc <= w_accNext;
            r_cnt <= r_cnt + CW'(1);
         end
         if (w_last) begin
            r_hi  <= w_resHi;
            r_lo  <= w_resLo;
            r_dbz <= w_dbz;
         end
      end
   end

   assign busy        = (r_state == CALC);
   assign done        = r_done;
   assign hi          = r_hi;
   assign lo          = r_lo;
   assign div_by_zero = r_dbz;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Directed self-checking bench for muldiv_unit
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [15:0] src_a;
   logic [15:0] src_b;
   logic        busy;
   logic        done;
   logic [15:0] hi;
   logic [15:0] lo;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;
   int lat;
   int bcnt;

   muldiv_unit #(.WIDTH(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .src_a       (src_a),
      .src_b       (src_b),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a request for one clock; returns at the negedge right after the accepting edge
   task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // n counts rising edges since the accepting edge; bounded so a missing done cannot hang
   task automatic waitDone(input int n0, output int n, output int b);
      n = n0;
      b = 0;
      while (done !== 1'b1 && n < 40) begin
         if (busy === 1'b1) b++;
         @(negedge clk);
         n++;
      end
   endtask

   task automatic runOp(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input string tag, input logic [31:0] expHiLo, input logic expDbz);
      issue(o, a, b);
      waitDone(0, lat, bcnt);
      chk({tag, "_latency"}, lat, 16);
      chk({tag, "_hilo"}, {hi, lo}, expHiLo);
      chk({tag, "_dbz"}, div_by_zero, expDbz);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      src_a = '0;
      src_b = '0;
      repeat (2) @(negedge clk);
      chk("rst_flags", {busy, done, div_by_zero}, 0);
      chk("rst_hilo", {hi, lo}, 0);
      rst_n = 1'b1;

      // MULTU full-scale: latency, busy width and done pulse width
      issue(2'b00, 16'hFFFF, 16'hFFFF);
      waitDone(0, lat, bcnt);
      chk("multu_latency", lat, 16);
      chk("multu_busy_cycles", bcnt, 16);
      chk("multu_busy_at_done", busy, 0);
      chk("multu_hilo", {hi, lo}, 32'hFFFE_0001);
      chk("multu_dbz", div_by_zero, 0);
      @(negedge clk);
      chk("multu_done_pulse", done, 0);

      runOp(2'b01, 16'hFFFD, 16'h0005, "mult_neg3x5",  32'hFFFF_FFF1, 1'b0);
      runOp(2'b01, 16'h8000, 16'h8000, "mult_min_sq",  32'h4000_0000, 1'b0);
      runOp(2'b11, 16'hFFF9, 16'h0002, "div_neg7_2",   32'hFFFF_FFFD, 1'b0);
      runOp(2'b10, 16'h0064, 16'h0007, "divu_100_7",   32'h0002_000E, 1'b0);
      runOp(2'b11, 16'h8000, 16'hFFFF, "div_min_m1",   32'h0000_8000, 1'b0);
      runOp(2'b10, 16'h1234, 16'h0000, "divu_by0",     32'h1234_FFFF, 1'b1);
      @(negedge clk);
      chk("dbz_hold", div_by_zero, 1);
      runOp(2'b00, 16'h0002, 16'h0003, "multu_2x3",    32'h0000_0006, 1'b0);

      // start while busy must be ignored, even with new operands on the bus
      issue(2'b00, 16'h0010, 16'h0003);
      repeat (4) @(negedge clk);
      chk("busy_hold_prev", {hi, lo}, 32'h0000_0006);
      start = 1'b1;
      op    = 2'b10;
      src_a = 16'hFFFF;
      src_b = 16'h0001;
      @(negedge clk);
      start = 1'b0;
      waitDone(5, lat, bcnt);
      chk("ignored_start_latency", lat, 16);
      chk("ignored_start_hilo", {hi, lo}, 32'h0000_0030);

      // back-to-back: second start raised during the done cycle
      issue(2'b00, 16'h0100, 16'h0100);
      waitDone(0, lat, bcnt);
      chk("b2b_first_hilo", {hi, lo}, 32'h0001_0000);
      start = 1'b1;
      op    = 2'b10;
      src_a = 16'h0064;
      src_b = 16'h0003;
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy", {busy, done}, 2'b10);
      chk("b2b_hold", {hi, lo}, 32'h0001_0000);
      waitDone(0, lat, bcnt);
      chk("b2b_latency", lat, 16);
      chk("b2b_second_hilo", {hi, lo}, 32'h0001_0021);

      // asynchronous reset in the middle of a calculation
      issue(2'b00, 16'hFFFF, 16'hFFFF);
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_flags", {busy, done, div_by_zero}, 0);
      chk("midrst_hilo", {hi, lo}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      chk("midrst_no_done", {busy, done}, 0);
      chk("midrst_hilo_after", {hi, lo}, 0);
      runOp(2'b01, 16'hFFFD, 16'h0005, "post_rst_mult", 32'hFFFF_FFF1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
